// File: rtl/seg_scan_display.sv
// seg_scan_display: binary-to-BCD load path feeding a multiplexed active-low 7-segment scanner
module seg_scan_display #(
  parameter int DIGITS    = 2,
  parameter int VAL_W     = 5,
  parameter int SCAN_DIV  = 4,
  parameter int BLINK_DIV = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [VAL_W-1:0]  value,
  input  logic              blank_lz,
  input  logic              blink_en,
  input  logic [DIGITS-1:0] dp,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  output logic [DIGITS-1:0] dig_sel,
  output logic [7:0]        seg
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = VAL_W > 1 ? $clog2(VAL_W) : 1;
  localparam int PW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam int KW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
  localparam logic [31:0] MAX_VAL = 32'(10 ** DIGITS - 1);
  localparam logic [15:0][7:0] SEG_LUT = {{6{8'hC0}}, 8'h90, 8'h80, 8'hF8, 8'h82, 8'h92,
                                          8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0};
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
  state_t state, state_n;
  logic [VAL_W-1:0] bin;
  logic [BW-1:0] bcd, bcd_adj, disp, sh;
  logic [CW-1:0] cnt;
  logic ovf_next;
  logic [PW-1:0] pre;
  logic [IW-1:0] idx;
  logic [KW-1:0] blk;
  logic phase, pre_wrap, idx_wrap, blk_wrap, blink_off, lz;
  logic [DIGITS-1:0] dig_n;
  logic [7:0] seg_n;

  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= state_n;

  always_comb
    state_n = state == IDLE  ? (load ? SHIFT : IDLE) :
              state == SHIFT ? (cnt == CW'(VAL_W - 1) ? COMMIT : SHIFT) : IDLE;

  always_comb busy = state != IDLE;

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < DIGITS; i++)
      bcd_adj[4*i+:4] = bcd[4*i+:4] > 4'd4 ? bcd[4*i+:4] + 4'd3 : bcd[4*i+:4];
  end

  always_ff @(posedge clk)
    if (!rst_n) begin
      bin      <= '0;
      bcd      <= '0;
      cnt      <= '0;
      ovf_next <= 1'b0;
      disp     <= '0;
      ovf      <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= state == COMMIT;
      if (state == IDLE && load) begin
        bin      <= value;
        bcd      <= '0;
        cnt      <= '0;
        ovf_next <= 32'(value) > MAX_VAL;
      end else if (state == SHIFT) begin
        {bcd, bin} <= {bcd_adj, bin} << 1;
        cnt        <= cnt + CW'(1);
      end
      if (state == COMMIT) begin
        disp <= bcd;
        ovf  <= ovf_next;
      end
    end

  always_comb begin
    pre_wrap  = pre == PW'(SCAN_DIV - 1);
    idx_wrap  = pre_wrap && idx == IW'(DIGITS - 1);
    blk_wrap  = idx_wrap && blk == KW'(BLINK_DIV - 1);
    blink_off = blink_en && !phase;
    sh        = disp >> {idx, 2'b00};
    lz        = blank_lz && idx != '0 && sh == '0;
    dig_n     = blink_off ? '1 : ~(DIGITS'(1) << idx);
    seg_n     = blink_off ? 8'hFF :
                {~dp[idx], ovf ? 7'h3F : lz ? 7'h7F : SEG_LUT[sh[3:0]][6:0]};
  end

  always_ff @(posedge clk)
    if (!rst_n) begin
      pre     <= '0;
      idx     <= '0;
      blk     <= '0;
      phase   <= 1'b1;
      dig_sel <= ~DIGITS'(1);
      seg     <= 8'hC0;
    end else begin
      pre     <= pre_wrap ? '0 : pre + PW'(1);
      idx     <= pre_wrap ? (idx_wrap ? '0 : idx + IW'(1)) : idx;
      blk     <= !blink_en ? '0 : idx_wrap ? (blk_wrap ? '0 : blk + KW'(1)) : blk;
      phase   <= !blink_en || (phase ^ blk_wrap);
      dig_sel <= dig_n;
      seg     <= seg_n;
    end
endmodule

// File: tb/tb_seg_scan_display.sv
// tb_seg_scan_display: vector table, corner sequences and random loads against an arithmetic display model
module tb_seg_scan_display;
  localparam int DIGITS = 2, VAL_W = 7, SCAN_DIV = 4, BLINK_DIV = 2;
  localparam int ROUND = DIGITS * SCAN_DIV;
  logic clk = 1'b0, rst_n = 1'b0, load = 1'b0, blank_lz = 1'b0, blink_en = 1'b0;
  logic [VAL_W-1:0] value = '0;
  logic [DIGITS-1:0] dp = '0;
  logic busy, done, ovf;
  logic [DIGITS-1:0] dig_sel;
  logic [7:0] seg;
  int n_cmp = 0, n_err = 0, done_cnt = 0;
  bit chk_en = 1'b0;

  seg_scan_display #(.DIGITS(DIGITS), .VAL_W(VAL_W), .SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value), .blank_lz(blank_lz),
    .blink_en(blink_en), .dp(dp), .busy(busy), .done(done), .ovf(ovf),
    .dig_sel(dig_sel), .seg(seg)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 30) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int p10(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r *= 10;
    return r;
  endfunction

  // Reference model: digits by division, scan position from a cycle count since reset
  logic [7:0] lut [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
  int cyc, wraps, conv_left, pend, m_disp, m_i;
  bit m_ovf, e_busy, e_done, m_off, m_lz;
  logic [DIGITS-1:0] e_dig;
  logic [7:0] e_seg, m_base;

  always @(posedge clk) begin
    if (!rst_n) begin
      cyc = 0; wraps = 0; conv_left = 0; m_disp = 0; m_ovf = 0;
      e_busy = 0; e_done = 0; e_dig = ~DIGITS'(1); e_seg = 8'hC0;
    end else begin
      m_i    = (cyc / SCAN_DIV) % DIGITS;
      m_off  = blink_en && ((wraps / BLINK_DIV) % 2 == 1);
      m_lz   = blank_lz && m_i > 0 && m_disp < p10(m_i);
      m_base = m_ovf ? 8'hBF : m_lz ? 8'hFF : lut[(m_disp / p10(m_i)) % 10];
      e_dig  = m_off ? '1 : ~(DIGITS'(1) << m_i);
      e_seg  = m_off ? 8'hFF : {~dp[m_i], m_base[6:0]};
      wraps  = !blink_en ? 0 : (cyc % ROUND == ROUND - 1) ? wraps + 1 : wraps;
      cyc++;
      e_done = conv_left == 1;
      if (conv_left == 1) begin
        m_disp = pend % p10(DIGITS);
        m_ovf  = pend > p10(DIGITS) - 1;
      end
      if (conv_left > 0) conv_left--;
      else if (load) begin
        pend = int'(value);
        conv_left = VAL_W + 1;
      end
      e_busy = conv_left > 0;
    end
  end

  always @(negedge clk)
    if (chk_en) begin
      check("model_dig_sel", dig_sel, e_dig);
      check("model_seg", seg, e_seg);
      check("model_busy", busy, e_busy);
      check("model_done", done, e_done);
      check("model_ovf", ovf, m_ovf);
    end

  always @(posedge clk) if (done) done_cnt++;

  task automatic do_load(input int v);
    load = 1'b1;
    value = VAL_W'(v);
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin @(negedge clk); n++; end
    check("idle_timeout", n < 40, 1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 40) begin @(negedge clk); n++; end
    check("done_timeout", n < 40, 1);
  endtask

  task automatic sample(input logic [DIGITS-1:0] sel, output logic [7:0] s);
    int n = 0;
    while (dig_sel !== sel && n < 20) begin @(negedge clk); n++; end
    check("scan_timeout", n < 20, 1);
    s = seg;
  endtask

  typedef struct {
    int v;
    bit blz;
    logic [1:0] dp;
    logic [7:0] s0, s1;
    bit ov;
  } vec_t;
  vec_t tv [9];

  initial begin
    int n, d0;
    logic [7:0] s;
    tv[0] = '{16,  1'b0, 2'b00, 8'h82, 8'hF9, 1'b0};
    tv[1] = '{9,   1'b1, 2'b10, 8'h90, 8'h7F, 1'b0};
    tv[2] = '{9,   1'b0, 2'b10, 8'h90, 8'h40, 1'b0};
    tv[3] = '{100, 1'b0, 2'b00, 8'hBF, 8'hBF, 1'b1};
    tv[4] = '{99,  1'b0, 2'b00, 8'h90, 8'h90, 1'b0};
    tv[5] = '{0,   1'b1, 2'b01, 8'h40, 8'hFF, 1'b0};
    tv[6] = '{127, 1'b0, 2'b11, 8'h3F, 8'h3F, 1'b1};
    tv[7] = '{50,  1'b1, 2'b00, 8'hC0, 8'h92, 1'b0};
    tv[8] = '{7,   1'b0, 2'b00, 8'hF8, 8'hC0, 1'b0};
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_dig_sel", dig_sel, 2'b10);
    check("rst_seg", seg, 8'hC0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ovf", ovf, 0);
    chk_en = 1'b1;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    d0 = done_cnt;
    do_load(16);
    n = 0;
    while (busy && n < 40) begin n++; @(negedge clk); end
    check("busy_len", n, VAL_W + 1);
    check("done_after_busy", done, 1);
    repeat (3) @(negedge clk);
    check("single_done", done_cnt - d0, 1);
    for (int t = 0; t < 9; t++) begin
      blank_lz = tv[t].blz;
      dp = tv[t].dp;
      wait_idle();
      do_load(tv[t].v);
      wait_done();
      @(negedge clk);
      sample(2'b10, s);
      check($sformatf("vec%0d_digit0", t), s, tv[t].s0);
      sample(2'b01, s);
      check($sformatf("vec%0d_digit1", t), s, tv[t].s1);
      check($sformatf("vec%0d_ovf", t), ovf, tv[t].ov);
    end
    wait_idle();
    d0 = done_cnt;
    do_load(88);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_busy", busy, 0);
    repeat (12) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);
    sample(2'b10, s);
    check("abort_digit0", s, 8'hC0);
    sample(2'b01, s);
    check("abort_digit1", s, 8'hC0);
    d0 = done_cnt;
    for (int c = 0; c < 20; c++) begin
      load = 1'b1;
      value = VAL_W'($urandom_range(0, 127));
      @(negedge clk);
    end
    load = 1'b0;
    repeat (30) @(negedge clk);
    check("spam_done_count", done_cnt - d0, 3);
    blink_en = 1'b1;
    n = 0;
    while (dig_sel !== 2'b11 && n < 60) begin @(negedge clk); n++; end
    check("blink_start_timeout", n < 60, 1);
    n = 0;
    while (dig_sel === 2'b11 && n < 60) begin @(negedge clk); n++; end
    check("blink_off_len", n, 2 * ROUND);
    n = 0;
    while (dig_sel !== 2'b11 && n < 60) begin @(negedge clk); n++; end
    check("blink_on_len", n, 2 * ROUND);
    repeat (3) @(negedge clk);
    blink_en = 1'b0;
    @(negedge clk);
    check("blink_release", dig_sel === 2'b11, 0);
    repeat (25) begin
      blank_lz = 1'($urandom_range(0, 1));
      dp = DIGITS'($urandom_range(0, 3));
      blink_en = $urandom_range(0, 3) == 0;
      load = 1'b1;
      value = VAL_W'($urandom_range(0, 127));
      @(negedge clk);
      load = 1'b0;
      repeat ($urandom_range(0, 14)) @(negedge clk);
    end
    blink_en = 1'b0;
    repeat (20) @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/seg_scan_display.md
Name: seg_scan_display

Overview: Parametrised multi-digit 7-segment display driver for the traffic-light countdown and any other numeric readout. It accepts a binary value through a load pulse and converts it to BCD sequentially using shift-and-add-3. It then time-multiplexes DIGITS common-anode digits with active-low segment and digit-select outputs. Added features: leading-zero blanking, per-digit decimal points, blink and overflow indication.

Parameters:
DIGITS, 2, number of digits driven (1..8)
VAL_W, 5, width of binary input value (1..26)
SCAN_DIV, 4, clk cycles each digit stays enabled (>=1)
BLINK_DIV, 256, full digit-scan rounds per blink half-period (>=1)

Ports:
clk  in  1  system clock, all logic rising-edge
rst_n  in  1  synchronous active-low reset
load  in  1  one-cycle strobe; value sampled when accepted
value  in  VAL_W  binary value to display
blank_lz  in  1  1 = blank leading zeros (digit 0 never blanked)
blink_en  in  1  1 = display flashes at blink rate
dp  in  DIGITS  per-digit decimal point, 1 = lit, bit0 = least significant digit
busy  out  1  conversion in progress, load ignored
done  out  1  one-cycle pulse when new digits are committed to display
ovf  out  1  latched value exceeds 10^DIGITS-1
dig_sel  out  DIGITS  digit enable, active low, one-hot-low or all ones
seg  out  8  segments {dp,g,f,e,d,c,b,a}, active low

Behaviour:
- Reset (rst_n=0 at an edge):
  - busy=0, done=0, ovf=0, display BCD register=0.
  - prescaler=0, digit index=0, blink phase=on.
  - dig_sel={all 1, bit0=0}, seg=8'hC0 ('0').
- Converter FSM:
  - IDLE: load=1 is accepted at edge k. The block captures value, computes ovf_next = (value > 10^DIGITS-1), clears shift registers and goes to SHIFT. busy=1 from cycle after edge k.
  - SHIFT: runs exactly VAL_W cycles. Each cycle, every BCD nibble >=5 gets +3, then {bcd,bin} shifts left by 1. BCD working width is 4*DIGITS; bits shifted beyond that are discarded, and ovf covers that case.
  - COMMIT: one cycle. Copies the BCD result to the display register and ovf_next to ovf, then returns to IDLE. done=1 and busy=0 in the cycle after the commit edge.
  - Total: new digits visible on seg from edge k+VAL_W+2 onward, subject to the scan position.
  - load while busy=1 is ignored with no queueing. load in the same cycle as commit is also ignored.
- Scan:
  - Prescaler counts 0..SCAN_DIV-1. At wrap, digit index advances, and wraps from DIGITS-1 to 0.
  - Each index wrap increments the blink counter (0..BLINK_DIV-1). At its wrap, blink phase toggles.
  - dig_sel and seg are registered: they reflect the index of the previous cycle, consistent with each other.
- Segment decode, active low:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
  - Nibbles >9 decode as C0. seg[7] is overwritten with ~dp[index].
- Blanking precedence, highest first:
  1. blink_en=1 and phase=off: dig_sel all ones, seg=8'hFF.
  2. ovf=1: every digit shows '-' (8'hBF), dp still applied.
  3. blank_lz=1 and the digit is above the most significant nonzero digit (index>0): seg=8'hFF, dig_sel still active, dp still applied.
  4. Otherwise: decoded digit.
- blink_en=0 forces phase=on and holds the blink counter at 0.
- Reset mid-conversion aborts to IDLE. The display register clears to 0 and no done pulse is issued.
- The converter and scan logic are independent. Committing mid-scan changes seg at the next registered update with no glitch beyond a one-cycle boundary.

Test Plan:
- Reset, then DIGITS=2, VAL_W=5, SCAN_DIV=4, idle → dig_sel alternates 10/01 every 4 clk. seg=C0 on both digits (with blank_lz=0) and FF on digit1 (with blank_lz=1).
- load value=16 at edge k → busy high for 6 cycles, done pulses once after edge k+6. Digit0 seg=82, digit1 seg=F9, ovf=0.
- value=9, blank_lz=1, dp=2'b10 → digit0 seg=90. Digit1 seg=7F (blank with dp lit). Repeat with blank_lz=0 → digit1=40.
- DIGITS=2, VAL_W=7, value=100 → ovf=1, both digits BF. Then load 99 → ovf=0, both digits 90.
- load pulsed every cycle for 20 cycles → exactly one conversion per 7-cycle window, no lost or corrupt digits. Assert rst_n=0 during SHIFT → busy=0, no done, display 0.
- blink_en=1, BLINK_DIV=2 → dig_sel all ones for 2*DIGITS*SCAN_DIV cycles, then active for the same duration, repeating. Deassert blink_en → display on next cycle.
